// File: rtl/gate_chk_pkg.sv
// Shared types and the golden truth table for the gate-bank checker.
// Bit order of the seven observed outputs is fixed by the BIT_* indices.
package gate_chk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int NUM_OUT  = 7;
  localparam int BIT_NOT  = 0;
  localparam int BIT_NAND = 1;
  localparam int BIT_NOR  = 2;
  localparam int BIT_AND  = 3;
  localparam int BIT_OR   = 4;
  localparam int BIT_XOR  = 5;
  localparam int BIT_XNOR = 6;

  function automatic logic [NUM_OUT-1:0] exp_vec(input logic x, input logic y);
    logic [NUM_OUT-1:0] v;
    v           = '0;
    v[BIT_NOT]  = ~x;
    v[BIT_NAND] = ~(x & y);
    v[BIT_NOR]  = ~(x | y);
    v[BIT_AND]  = x & y;
    v[BIT_OR]   = x | y;
    v[BIT_XOR]  = x ^ y;
    v[BIT_XNOR] = ~(x ^ y);
    return v;
  endfunction

endpackage

// File: rtl/gate_truth_checker_golden_lut.sv
// Behavioural reference for the gate bank: maps {x,y} to the ideal outputs,
// independent of the switch-level cells under test.
module gate_golden_lut
  import gate_chk_pkg::*;
(
  input  logic               x,
  input  logic               y,
  output logic [NUM_OUT-1:0] exp_out
);

  assign exp_out = exp_vec(x, y);

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps x/y over all four vectors, samples the gate bank after a settle
// delay and accumulates a mismatch count, per-output fail mask and pass flag.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       not_x,
  input  logic       nand_out,
  input  logic       nor_out,
  input  logic       and_out,
  input  logic       or_out,
  input  logic       xor_out,
  input  logic       xnor_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] fail_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         idx;
  logic [NUM_OUT-1:0] obs;
  logic [NUM_OUT-1:0] exp_v;
  logic [NUM_OUT-1:0] diff;
  logic               any_diff;

  assign obs = {xnor_out, xor_out, or_out, and_out, nor_out, nand_out, not_x};

  gate_golden_lut u_lut (
    .x       (idx[1]),
    .y       (idx[0]),
    .exp_out (exp_v)
  );

  // Case inequality per bit so an X/Z from a broken cell is a failure.
  always_comb begin
    diff = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      diff[i] = (obs[i] !== exp_v[i]);
    end
    any_diff = |diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'b11) ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx wraps 11 -> 00 on the last sample, so x/y are back at 00 in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      err_count <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt       <= '0;
            idx       <= '0;
            err_count <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
          end
        end
        SETTLE: cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        SAMPLE: begin
          fail_mask <= fail_mask | diff;
          err_count <= err_count + 3'(any_diff);
          idx       <= idx + 2'd1;
          if (idx == 2'b11) pass <= (err_count == 3'd0) && !any_diff;
        end
        default: ;
      endcase
    end
  end

  assign x    = idx[1];
  assign y    = idx[0];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
